tick_gen_multi: RTL and testbench

Parametrised multi-channel tick generator for the sensor and clock subsystems. A shared prescaler divides iClk down to a base tick, 1 us at defaults. NUM_CH independent channels then divide that base tick by runtime-loadable divisors, giving ultrasonic trigger and timeout timing, display refresh and similar strobes from one block. Each channel runs continuously or as an armed one-shot with busy/done status.

---
 rtl/tick_gen_multi.sv | 121 ++++++++++++
 tb/tb_tick_gen_multi.sv | 136 +++++++++++++
 2 files changed

// File: rtl/tick_gen_multi.sv
// tick_gen_multi: shared prescaler feeding NUM_CH loadable tick dividers; one-shot mode is built only with TICK_GEN_ONESHOT_EN
module tick_gen_multi #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int BASE_HZ = 1_000_000,
  parameter int NUM_CH  = 2,
  parameter int DIV_W   = 16
) (
  input  logic                    iClk,
  input  logic                    iRst,
  input  logic                    iRun_Stop,
  input  logic                    iClear,
  input  logic [NUM_CH-1:0]       iLoad,
  input  logic [NUM_CH*DIV_W-1:0] iDiv,
  input  logic [NUM_CH-1:0]       iOneShot,
  input  logic [NUM_CH-1:0]       iChEn,
  output logic                    oBaseTick,
  output logic [NUM_CH-1:0]       oTick,
  output logic [NUM_CH-1:0]       oBusy,
  output logic [NUM_CH-1:0]       oDone
);
  localparam int PRE = CLK_HZ / BASE_HZ;
  localparam int PW  = $clog2(PRE);
  logic [PW-1:0]                pre_q, pre_d;
  logic                         base_tick_q, base_tick_d, w_base;
  logic [NUM_CH-1:0][DIV_W-1:0] div_q, div_d, cnt_q, cnt_d, last_cnt;
  logic [NUM_CH-1:0]            armed_q, armed_d, tick_q, tick_d;
`ifdef TICK_GEN_ONESHOT_EN
  logic [NUM_CH-1:0]            mode_q, mode_d, done_q, done_d;
`else
  logic                         unused_oneshot;
  assign unused_oneshot = ^iOneShot;
`endif
  // base strobe and prescaler phase; clear restarts the phase and swallows the strobe
  always_comb begin
    w_base      = iRun_Stop & ~iClear & (pre_q == PW'(PRE - 1));
    pre_d       = (iClear | w_base) ? '0 : pre_q + PW'(iRun_Stop);
    base_tick_d = w_base;
  end
  // terminal count per channel; a zero divisor behaves as divide-by-one
  always_comb begin
    last_cnt = '0;
    for (int k = 0; k < NUM_CH; k++)
      last_cnt[k] = (div_q[k] == '0) ? '0 : div_q[k] - 1'b1;
  end
  // channel next state, priority clear > load > counted base strobe
  always_comb begin
    div_d   = div_q;
    cnt_d   = cnt_q;
    armed_d = armed_q;
    tick_d  = '0;
`ifdef TICK_GEN_ONESHOT_EN
    mode_d  = mode_q;
    done_d  = done_q;
`endif
    for (int k = 0; k < NUM_CH; k++) begin
      if (iClear) begin
        cnt_d[k] = '0;
`ifdef TICK_GEN_ONESHOT_EN
        done_d[k] = 1'b0;
`endif
      end else if (iLoad[k]) begin
        div_d[k]   = iDiv[k*DIV_W +: DIV_W];
        cnt_d[k]   = '0;
        armed_d[k] = 1'b1;
`ifdef TICK_GEN_ONESHOT_EN
        mode_d[k]  = iOneShot[k];
        done_d[k]  = 1'b0;
`endif
      end else if (w_base & armed_q[k] & iChEn[k]) begin
        if (cnt_q[k] == last_cnt[k]) begin
          cnt_d[k]  = '0;
          tick_d[k] = 1'b1;
`ifdef TICK_GEN_ONESHOT_EN
          if (mode_q[k]) begin
            armed_d[k] = 1'b0;
            done_d[k]  = 1'b1;
          end
`endif
        end else begin
          cnt_d[k] = cnt_q[k] + 1'b1;
        end
      end
    end
  end
  // shared and per-channel state; channels come out of reset idle with divisor 1
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      pre_q       <= '0;
      base_tick_q <= 1'b0;
      div_q       <= {NUM_CH{DIV_W'(1)}};
      cnt_q       <= '0;
      armed_q     <= '0;
      tick_q      <= '0;
    end else begin
      pre_q       <= pre_d;
      base_tick_q <= base_tick_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      armed_q     <= armed_d;
      tick_q      <= tick_d;
    end
  end
`ifdef TICK_GEN_ONESHOT_EN
  // one-shot mode and sticky completion flags
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      mode_q <= '0;
      done_q <= '0;
    end else begin
      mode_q <= mode_d;
      done_q <= done_d;
    end
  end
  assign oDone = done_q;
`else
  assign oDone = '0;
`endif
  assign oBaseTick = base_tick_q;
  assign oTick     = tick_q;
  assign oBusy     = armed_q & iChEn;
endmodule

// File: tb/tb_tick_gen_multi.sv
// tb_tick_gen_multi: directed checks of prescaler, channel dividers, priorities and reset
module tb_tick_gen_multi;
  logic        iClk = 1'b0, iRst = 1'b1, iRun_Stop = 1'b0, iClear = 1'b0;
  logic [1:0]  iLoad = '0, iOneShot = '0, iChEn = 2'b11;
  logic [31:0] iDiv = '0;
  logic        oBaseTick;
  logic [1:0]  oTick, oBusy, oDone;
  int n_chk = 0, n_fail = 0;
  int ci, nb, bad;
  int nt[2], first_t[2], last_t[2], nlo[2], lo_t[2], done_t[2];
  tick_gen_multi #(
    .CLK_HZ(100_000_000), .BASE_HZ(1_000_000), .NUM_CH(2), .DIV_W(16)
  ) dut (
    .iClk(iClk), .iRst(iRst), .iRun_Stop(iRun_Stop), .iClear(iClear),
    .iLoad(iLoad), .iDiv(iDiv), .iOneShot(iOneShot), .iChEn(iChEn),
    .oBaseTick(oBaseTick), .oTick(oTick), .oBusy(oBusy), .oDone(oDone)
  );
  always #5 iClk = ~iClk;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic stats_clr();
    ci = 0; nb = 0; bad = 0;
    for (int k = 0; k < 2; k++) begin
      nt[k] = 0; first_t[k] = -1; last_t[k] = -1; nlo[k] = 0; lo_t[k] = -1; done_t[k] = -1;
    end
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge iClk); #1;
      ci++;
      if (oBaseTick) begin
        nb++;
        if (ci % 100 != 0) bad++;
      end
      for (int k = 0; k < 2; k++) begin
        if (oTick[k]) begin
          nt[k]++;
          if (first_t[k] < 0) first_t[k] = ci;
          last_t[k] = ci;
          if (!oBaseTick) bad++;
        end
        if (!oBusy[k]) begin
          nlo[k]++;
          if (lo_t[k] < 0) lo_t[k] = ci;
        end
        if (oDone[k] && done_t[k] < 0) done_t[k] = ci;
      end
    end
  endtask
  task automatic clear_pulse();
    iClear = 1'b1;
    @(posedge iClk); #1;
    iClear = 1'b0;
    stats_clr();
  endtask
  task automatic load(input int k, input int d, input logic os);
    iLoad[k] = 1'b1;
    iDiv[k*16 +: 16] = 16'(d);
    iOneShot[k] = os;
    run(1);
    iLoad = '0;
  endtask
  initial begin
    repeat (3) @(posedge iClk);
    #1 chk("rst_outs", int'({oBaseTick, oTick, oBusy, oDone}), 0);
    iRst = 1'b0; iRun_Stop = 1'b1; stats_clr();
    run(1000);
    chk("idle_base_cnt", nb, 10);
    chk("idle_base_pos", bad, 0);
    chk("idle_ticks", nt[0] + nt[1], 0);
    chk("idle_busy_lo", nlo[0] + nlo[1], 2000);
    chk("idle_done", done_t[0] + done_t[1], -2);
    clear_pulse(); load(0, 10, 1'b0); run(2999);
    chk("cont_ticks", nt[0], 3);
    chk("cont_first", first_t[0], 1000);
    chk("cont_last", last_t[0], 3000);
    chk("cont_align", bad, 0);
    chk("cont_busy", nlo[0], 0);
    clear_pulse(); load(1, 3, 1'b1); run(5299);
    chk("os_first", first_t[1], 300);
`ifdef TICK_GEN_ONESHOT_EN
    chk("os_ticks", nt[1], 1);
    chk("os_done_t", done_t[1], 300);
    chk("os_busy_fall", lo_t[1], 300);
    chk("os_done_sticky", int'(oDone[1]), 1);
`else
    chk("os_ticks", nt[1], 17);
    chk("os_done", done_t[1], -1);
    chk("os_busy", nlo[1], 0);
`endif
    clear_pulse();
    chk("clr_done", int'(oDone[1]), 0);
    load(0, 0, 1'b0); run(999);
    chk("d0_ticks", nt[0], 10);
    chk("d0_first", first_t[0], 100);
    clear_pulse(); load(0, 1, 1'b0); run(999);
    chk("d1_ticks", nt[0], 10);
    chk("d1_first", first_t[0], 100);
    clear_pulse(); load(0, 10, 1'b0); run(649);
    iRun_Stop = 1'b0; stats_clr(); run(250);
    chk("stop_base", nb, 0);
    chk("stop_ticks", nt[0], 0);
    clear_pulse(); iRun_Stop = 1'b1; run(1000);
    chk("resume_ticks", nt[0], 1);
    chk("resume_first", first_t[0], 1000);
    chk("resume_busy", nlo[0], 0);
    clear_pulse(); run(99); load(0, 10, 1'b0); run(1000);
    chk("ldbase_base", nb, 11);
    chk("ldbase_ticks", nt[0], 1);
    chk("ldbase_first", first_t[0], 1100);
    clear_pulse(); load(0, 10, 1'b0); run(499);
    iChEn = 2'b10; run(1000);
    chk("dis_ticks", nt[0], 0);
    chk("dis_busy_lo", nlo[0], 1000);
    iChEn = 2'b11; run(500);
    chk("en_ticks", nt[0], 1);
    chk("en_first", first_t[0], 2000);
    clear_pulse(); run(100);
    chk("pre_rst_base", int'(oBaseTick), 1);
    chk("pre_rst_busy", int'(oBusy[0]), 1);
    iRst = 1'b1; #1;
    chk("async_rst", int'({oBaseTick, oTick, oBusy, oDone}), 0);
    @(posedge iClk); #1;
    iRst = 1'b0; stats_clr(); run(2000);
    chk("post_rst_base", nb, 20);
    chk("post_rst_ticks", nt[0] + nt[1], 0);
    chk("post_rst_busy", nlo[0] + nlo[1], 4000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
